prio_encoder_hs: RTL and testbench
==================================

Name: prio_encoder_hs

Overview:
- Parametrised, registered N-to-log2(N) priority encoder with an enable and a valid/ready output handshake.
- Generalises the fixed 8-to-3 encoder: width is a parameter, it flags idle (all-zero) and multi-hot inputs, and it holds its result until a downstream consumer accepts it.
- Sits between request/interrupt-style one-hot or multi-hot sources and a consumer that takes one encoded index per transaction.

Parameters:
- N, 8, number of request inputs; legal range 2..256.
- W, $clog2(N) (localparam, not overridable), width of the encoded index.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable; when 0, no new result is accepted.
- req  in  N  request vector; bit i maps to code i.
- out_valid  out  1  registered result is held and valid.
- out_ready  in  1  consumer accepts the result this cycle.
- code  out  W  encoded index of the highest-priority set bit.
- multi  out  1  more than one req bit was set at capture.
- any  out  1  combinational: en & (|req), unregistered.

Behaviour:
- Reset values:
  - out_valid=0, code=0, multi=0.
  - Round-robin pointer (optional feature) = N-1.
  - Reset is asynchronous and takes effect immediately, mid-transaction included; any held result is discarded.
- Fixed priority:
  - The highest set index wins (bit N-1 highest, bit 0 lowest).
- Register slot states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Load condition: load = en & (|req) & (!out_valid | out_ready).
- On load:
  - code <= winner index.
  - multi <= (popcount(req) > 1).
  - out_valid <= 1.
- Transitions:
  - EMPTY -> FULL on load.
  - FULL -> FULL on load while out_ready=1. Back-to-back throughput is one result per cycle.
  - FULL -> EMPTY when out_ready=1 and no load.
  - FULL with out_ready=0: code and multi are held stable. req changes are ignored (no overwrite, no drop of the held result).
- Latency:
  - req sampled at edge k appears on code at edge k (visible in cycle k+1).
  - A one-cycle registered latency.
- req all zero, or en=0: nothing is captured. A FULL slot still drains on out_ready.
- out_ready while EMPTY: no effect.
- req is level-sampled; no edge detection; a held req reloads every accepted cycle.
- code is W bits; for N not a power of two, indices >= N are never produced.

Optional Feature:
- Macro: PRIO_ENC_RR_EN.
- Defined:
  - A W-bit pointer p selects the highest-priority index.
  - The search runs descending from p, wrapping from 0 to N-1.
  - On every load with winner g, p <= (g==0) ? N-1 : g-1. The winner becomes lowest priority next time.
  - p is unchanged on cycles with no load.
  - Reset p=N-1, so the first grant matches fixed priority.
- Undefined:
  - Strict fixed priority as above; no pointer register exists.

Decomposition:
- Package prio_enc_pkg holds:
  - function clog2_safe.
  - function popcount_gt1(vector): the multi-hot detect.
  - The rotate helper used by round-robin.
- One natural sub-module: prio_pick (combinational).
  - Inputs: req and start index.
  - Outputs: winner index and found flag.
  - Fixed mode ties start to N-1.
  - The top level owns the slot register, handshake and pointer.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst_n=0 mid-FULL with code=5.
  - Required: out_valid=0 and code=0 immediately (asynchronous); after release with req=0, out_valid stays 0.
- Walking one, N=8, en=1, out_ready=1:
  - Stimulus: req=0x80, 0x40, … 0x01 on consecutive cycles.
  - Required: code=7..0 one cycle later each; multi=0; out_valid=1 continuously.
- Enable gating:
  - Stimulus: en=0, req=0x80.
  - Required: out_valid stays 0 and any=0; set en=1, next cycle code=7.
- Multi-hot and backpressure:
  - Stimulus: req=0x2C, out_ready=0.
  - Required: code=5, multi=1.
  - Then change req to 0x01 for 3 cycles: code stays 5.
  - Raise out_ready: next cycle code=0, multi=0.
- Round-robin (PRIO_ENC_RR_EN):
  - Stimulus: req=0x91 held, out_ready=1.
  - Required: code sequence 7,4,0,7,4; without the macro, the same stimulus gives 7,7,7,7,7.
- Non-power-of-two N=5 (W=3):
  - Stimulus: req=5'b10010.
  - Required: code=4, multi=1.
  - Then req=5'b00001: code=0; code never exceeds 4.

Source files
------------

// File: rtl/prio_encoder_hs_pkg.sv
// prio_enc_pkg: shared width, multi-hot and wrap helpers for the priority encoder
package prio_enc_pkg;
    localparam int MAX_N = 256;

    function automatic int clog2_safe(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic popcount_gt1(input logic [MAX_N-1:0] v);
        return |(v & (v - {{(MAX_N-1){1'b0}}, 1'b1}));
    endfunction

    function automatic int wrap_sub(input int a, input int k, input int n);
        return (a >= k) ? a - k : a + n - k;
    endfunction
endpackage

// File: rtl/prio_encoder_hs_if.sv
// prio_enc_if: request/enable inputs and valid/ready result bundle of the encoder
interface prio_enc_if #(parameter int N = 8);
    localparam int W = prio_enc_pkg::clog2_safe(N);
    logic en;
    logic [N-1:0] req;
    logic out_valid;
    logic out_ready;
    logic [W-1:0] code;
    logic multi;
    logic any;
    modport master (input en, req, out_ready, output out_valid, code, multi, any);
    modport slave (output en, req, out_ready, input out_valid, code, multi, any);
endinterface

// File: rtl/prio_encoder_hs_pick.sv
// prio_pick: descending search for a set request starting at start, wrapping to N-1
module prio_pick
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    localparam int W = clog2_safe(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] winner,
    output logic         found
);
    always_comb begin
        winner = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = wrap_sub(int'(start), k, N);
            if (req[idx]) begin
                winner = W'(idx);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/prio_encoder_hs.sv
// prio_encoder_hs: registered priority encoder with valid/ready hold; PRIO_ENC_RR_EN selects round-robin
module prio_encoder_hs
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    localparam int W = clog2_safe(N)
) (
    input logic clk,
    input logic rst_n,
    prio_enc_if.master bus
);
    logic [W-1:0] start, winner, code_q;
    logic found, load, valid_q, multi_q;

    prio_pick #(.N(N)) u_pick (
        .req(bus.req),
        .start(start),
        .winner(winner),
        .found(found)
    );

    assign load = bus.en & found & (~valid_q | bus.out_ready);
    assign bus.any = bus.en & (|bus.req);
    assign bus.out_valid = valid_q;
    assign bus.code = code_q;
    assign bus.multi = multi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            code_q <= '0;
            multi_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            code_q <= winner;
            multi_q <= popcount_gt1(MAX_N'(bus.req));
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef PRIO_ENC_RR_EN
    logic [W-1:0] ptr;

    // the winner drops to lowest priority for the next grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= W'(N - 1);
        else if (load) ptr <= (winner == '0) ? W'(N - 1) : winner - 1'b1;
    end

    assign start = ptr;
`else
    assign start = W'(N - 1);
`endif
endmodule

// File: tb/tb_prio_encoder_hs.sv
// tb_prio_encoder_hs: directed and random checks of N=8 and N=5 encoders against a queue-free model
module tb_prio_encoder_hs;
    typedef struct {
        bit v;
        int c;
        bit m;
        int p;
    } model_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic rdy = 1'b1;
    logic [7:0] req8 = '0;
    logic [4:0] req5 = '0;
    int tests = 0;
    int fails = 0;
    model_t m8, m5, n8, n5;

    always #5 clk = ~clk;

    prio_enc_if #(.N(8)) i8 ();
    prio_enc_if #(.N(5)) i5 ();

    assign i8.en = en;
    assign i8.req = req8;
    assign i8.out_ready = rdy;
    assign i5.en = en;
    assign i5.req = req5;
    assign i5.out_ready = rdy;

    prio_encoder_hs #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));
    prio_encoder_hs #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(i5));

    function automatic model_t mnext(input model_t s, input int n, input bit e,
                                     input logic [255:0] r, input bit rd);
        model_t o = s;
        int cnt = 0;
        int g = -1;
        int st;
        for (int i = 0; i < n; i++) cnt += int'(r[i]);
`ifdef PRIO_ENC_RR_EN
        st = s.p;
`else
        st = n - 1;
`endif
        for (int k = 0; k < n; k++)
            if (g < 0 && r[(st - k + n) % n]) g = (st - k + n) % n;
        if (e && cnt > 0 && (!s.v || rd)) begin
            o.v = 1;
            o.c = g;
            o.m = cnt > 1;
            o.p = (g == 0) ? n - 1 : g - 1;
        end else if (rd) begin
            o.v = 0;
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/valid8"}, 32'(i8.out_valid), 32'(m8.v));
        chk({tag, "/code8"}, 32'(i8.code), 32'(m8.c));
        chk({tag, "/multi8"}, 32'(i8.multi), 32'(m8.m));
        chk({tag, "/any8"}, 32'(i8.any), 32'(en && req8 != 0));
        chk({tag, "/valid5"}, 32'(i5.out_valid), 32'(m5.v));
        chk({tag, "/code5"}, 32'(i5.code), 32'(m5.c));
        chk({tag, "/multi5"}, 32'(i5.multi), 32'(m5.m));
        chk({tag, "/any5"}, 32'(i5.any), 32'(en && req5 != 0));
    endtask

    task automatic cycle(input string tag);
        n8 = mnext(m8, 8, en, 256'(req8), rdy);
        n5 = mnext(m5, 5, en, 256'(req5), rdy);
        @(posedge clk);
        #1;
        m8 = n8;
        m5 = n5;
        check_all(tag);
    endtask

    task automatic model_reset();
        m8 = '{v: 0, c: 0, m: 0, p: 7};
        m5 = '{v: 0, c: 0, m: 0, p: 4};
    endtask

    initial begin
        int rr_exp[5];
`ifdef PRIO_ENC_RR_EN
        rr_exp = '{7, 4, 0, 7, 4};
`else
        rr_exp = '{7, 7, 7, 7, 7};
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        cycle("idle");

        en = 1'b1;
        rdy = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            req8 = 8'(1 << i);
            cycle("walk");
            chk("walk_code", 32'(i8.code), 32'(i));
            chk("walk_valid", 32'(i8.out_valid), 32'd1);
        end

        en = 1'b0;
        req8 = 8'h80;
        cycle("gate_drain");
        cycle("gate_idle");
        chk("gate_valid", 32'(i8.out_valid), 32'd0);
        chk("gate_any", 32'(i8.any), 32'd0);
        en = 1'b1;
        cycle("gate_on");
        chk("gate_code", 32'(i8.code), 32'd7);

        en = 1'b0;
        cycle("drain");
        en = 1'b1;
        rdy = 1'b0;
        req8 = 8'h2C;
        cycle("mh_load");
        chk("mh_code", 32'(i8.code), 32'd5);
        chk("mh_multi", 32'(i8.multi), 32'd1);
        req8 = 8'h01;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            chk("bp_code", 32'(i8.code), 32'd5);
        end
        rdy = 1'b1;
        cycle("bp_release");
        chk("bp_rel_code", 32'(i8.code), 32'd0);
        chk("bp_rel_multi", 32'(i8.multi), 32'd0);

        req8 = 8'h91;
        for (int i = 0; i < 5; i++) begin
            cycle("rr");
            chk($sformatf("rr_code%0d", i), 32'(i8.code), 32'(rr_exp[i]));
        end

        req8 = 8'h00;
        req5 = 5'b10010;
        cycle("n5_multi");
        chk("n5_code", 32'(i5.code), 32'd4);
        chk("n5_multi", 32'(i5.multi), 32'd1);
        req5 = 5'b00001;
        cycle("n5_low");
        chk("n5_low_code", 32'(i5.code), 32'd0);

        req5 = 5'b0;
        req8 = 8'h20;
        rdy = 1'b0;
        cycle("ar_load");
        chk("ar_pre_code", 32'(i8.code), 32'd5);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_valid", 32'(i8.out_valid), 32'd0);
        chk("ar_code", 32'(i8.code), 32'd0);
        req8 = 8'h00;
        rdy = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("ar_idle1");
        cycle("ar_idle2");
        chk("ar_stay", 32'(i8.out_valid), 32'd0);

        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            req8 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7)) & 8'($urandom_range(0, 255) | 1);
            req5 = ($urandom_range(0, 5) == 0) ? 5'b0 : 5'($urandom);
            cycle("rand");
            chk("rand_code5_range", 32'(i5.code <= 3'd4), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
